// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: sequences one MAC processing element and the result RAM.
// A job computes N dot products of length K. Each result goes through
// CLEAR -> FEED -> SETTLE -> WRITE, and the results land at consecutive RAM
// addresses starting at a latched base. Control outputs decode the state
// register directly, so the asynchronous reset forces them low at once.
module pe_mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W:0]   num_res,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_north,
  input  logic [DATA_W-1:0] op_west,
  output logic              pe_clr,
  output logic [DATA_W-1:0] pe_north,
  output logic [DATA_W-1:0] pe_west,
  input  logic [ACC_W-1:0]  pe_result,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ACC_W-1:0]  ram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   res_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_SETTLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W:0]    num_q;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   op_cnt;
  logic [LEN_W-1:0]   op_cnt_inc;
  logic [ADDR_W:0]    res_inc;
  logic               hs;
  logic               last_op;
  logic               last_res;

  assign hs         = (state == S_FEED) && op_valid;
  assign op_cnt_inc = op_cnt + 1'b1;
  assign last_op    = (op_cnt_inc == len_q);
  assign res_inc    = res_idx + 1'b1;
  assign last_res   = (res_inc == num_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-decoded control outputs
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    pe_clr    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_res == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_clr    = 1'b1;
        state_nxt = (len_q != '0) ? S_FEED : S_SETTLE;
      end
      S_FEED: begin
        op_ready = 1'b1;
        if (op_valid && last_op) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = base_q + res_idx[ADDR_W-1:0];
        ram_din   = pe_result;
        state_nxt = last_res ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Job parameters, operand counter and result index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      num_q   <= '0;
      base_q  <= '0;
      op_cnt  <= '0;
      res_idx <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q   <= len;
        num_q   <= num_res;
        base_q  <= base_addr;
        res_idx <= '0;
      end
      if (state == S_CLEAR) begin
        op_cnt <= '0;
      end else if (hs) begin
        op_cnt <= op_cnt_inc;
      end
      if (state == S_WRITE) begin
        res_idx <= res_inc;
      end
    end
  end

  // PE operand registers: load only on a handshake, otherwise feed zeros so
  // the PE accumulates nothing during bubbles, CLEAR, SETTLE and WRITE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_north <= '0;
      pe_west  <= '0;
    end else if (hs) begin
      pe_north <= op_north;
      pe_west  <= op_west;
    end else begin
      pe_north <= '0;
      pe_west  <= '0;
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Testbench for pe_mac_sequencer: directed and random jobs against a
// result-level reference model, with a behavioural MAC PE attached.
module tb_pe_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W:0]   num_res = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DATA_W-1:0] op_north = '0;
  logic [DATA_W-1:0] op_west = '0;
  logic              pe_clr;
  logic [DATA_W-1:0] pe_north;
  logic [DATA_W-1:0] pe_west;
  logic [ACC_W-1:0]  pe_result;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [ACC_W-1:0]  ram_din;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   res_idx;

  pe_mac_sequencer #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .num_res  (num_res),
    .base_addr(base_addr),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_north (op_north),
    .op_west  (op_west),
    .pe_clr   (pe_clr),
    .pe_north (pe_north),
    .pe_west  (pe_west),
    .pe_result(pe_result),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .busy     (busy),
    .done     (done),
    .res_idx  (res_idx)
  );

  always #5 clk = ~clk;

  // Behavioural PE: synchronous clear, otherwise accumulate north*west
  logic [ACC_W-1:0] acc;
  always @(posedge clk or negedge rst) begin
    if (!rst)        acc <= '0;
    else if (pe_clr) acc <= '0;
    else             acc <= acc + ACC_W'(pe_north) * ACC_W'(pe_west);
  end
  assign pe_result = acc;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: cycle 1 is the cycle after the edge that samples start
  typedef struct {
    int     c;
    int     a;
    longint d;
  } wr_t;

  wr_t wrs[$];
  int  cyc = 0;
  int  s0 = 0;
  bit  rec = 1'b0;
  int  mc;
  int  clr_cnt, done_cnt, done_cyc, nz_cnt, busy_after;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rec) begin
      mc = cyc - s0 + 1;
      if (ram_we) wrs.push_back('{mc, int'(ram_addr), longint'(ram_din)});
      if (pe_clr) clr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = mc;
      end
      if (pe_north != '0 || pe_west != '0) nz_cnt++;
      if (done_cyc >= 0 && mc == done_cyc + 1) busy_after = int'(busy);
    end
  end

  // Operand stream for the next job: pairs, and bubble cycles before each pair
  int unsigned nq[$];
  int unsigned wq[$];
  int unsigned gq[$];

  task automatic add_pair(input int unsigned n, input int unsigned w, input int unsigned gap);
    nq.push_back(n);
    wq.push_back(w);
    gq.push_back(gap);
  endtask

  task automatic clear_ops();
    nq.delete();
    wq.delete();
    gq.delete();
  endtask

  task automatic clear_mon();
    wrs.delete();
    clr_cnt    = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    nz_cnt     = 0;
    busy_after = -1;
  endtask

  task automatic run_job(input int k, input int n, input int base, input bit glitch);
    int     total, idx, gap_left, budget, post, bsum, nz_exp;
    bit     hs, glitched;
    longint sum;
    int     exp_cyc[$];
    longint exp_dat[$];

    // Reference model: each result sums its K products; each FEED bubble
    // delays that result and every later event by one cycle.
    total  = k * n;
    bsum   = 0;
    nz_exp = 0;
    for (int j = 0; j < n; j++) begin
      sum = 0;
      for (int i = 0; i < k; i++) begin
        sum  += longint'(nq[j*k+i]) * longint'(wq[j*k+i]);
        bsum += int'(gq[j*k+i]);
        if (nq[j*k+i] != 0 || wq[j*k+i] != 0) nz_exp++;
      end
      exp_dat.push_back(sum & 64'hFFFF_FFFF);
      exp_cyc.push_back((j + 1) * (k + 3) + bsum);
    end

    clear_mon();
    @(negedge clk);
    len       = LEN_W'(k);
    num_res   = (ADDR_W+1)'(n);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    op_valid  = 1'b0;
    rec       = 1'b1;
    @(posedge clk);
    #1 s0 = cyc;

    idx      = 0;
    gap_left = (total > 0) ? int'(gq[0]) : 0;
    budget   = 500;
    post     = 0;
    glitched = 1'b0;
    while (budget > 0 && post < 2) begin
      @(negedge clk);
      start = 1'b0;
      if (glitch && !glitched && op_ready) begin
        start     = 1'b1;
        len       = LEN_W'(5);
        num_res   = '0;
        base_addr = ADDR_W'(9);
        glitched  = 1'b1;
      end
      if (idx < total && gap_left == 0) begin
        op_valid = 1'b1;
        op_north = DATA_W'(nq[idx]);
        op_west  = DATA_W'(wq[idx]);
      end else begin
        op_valid = 1'b0;
        op_north = DATA_W'($urandom_range(1, 255));
        op_west  = DATA_W'($urandom_range(1, 255));
        if (idx < total && op_ready) gap_left--;
      end
      hs = op_valid && op_ready;
      @(posedge clk);
      if (hs) begin
        idx++;
        gap_left = (idx < total) ? int'(gq[idx]) : 0;
      end
      if (done_cnt > 0) post++;
      budget--;
    end
    @(negedge clk);
    rec      = 1'b0;
    start    = 1'b0;
    op_valid = 1'b0;

    check("job_timeout", longint'(budget == 0), 0);
    check("num_writes", wrs.size(), n);
    for (int j = 0; j < n && j < wrs.size(); j++) begin
      check("wr_addr", wrs[j].a, (base + j) % 64);
      check("wr_data", wrs[j].d, exp_dat[j]);
      check("wr_cycle", wrs[j].c, exp_cyc[j]);
    end
    check("done_cycle", done_cyc, (n == 0) ? 1 : n * (k + 3) + 1 + bsum);
    check("done_count", done_cnt, 1);
    check("busy_after_done", busy_after, 0);
    check("pe_clr_count", clr_cnt, n);
    check("res_idx_end", res_idx, n);
    check("pe_nonzero_cycles", nz_cnt, nz_exp);
  endtask

  initial begin
    int k, n, b;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_pe_clr", pe_clr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pe_north", pe_north, 0);
    check("rst_pe_west", pe_west, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_res_idx", res_idx, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single result: 2*3 + 4*5 = 26 at addr 0, write in cycle 5
    clear_ops();
    add_pair(2, 3, 0);
    add_pair(4, 5, 0);
    run_job(2, 1, 0, 1'b0);

    // Two results from base 5: 1 and 21
    clear_ops();
    add_pair(1, 1, 0);
    add_pair(3, 7, 0);
    run_job(1, 2, 5, 1'b0);

    // Three-cycle bubble between the pairs
    clear_ops();
    add_pair(2, 3, 0);
    add_pair(4, 5, 3);
    run_job(2, 1, 0, 1'b0);

    // Address wrap from 63 to 0
    clear_ops();
    add_pair(255, 255, 0);
    add_pair(2, 2, 0);
    run_job(1, 2, 63, 1'b0);

    // K=0, then N=0, then a start pulse during FEED
    clear_ops();
    run_job(0, 1, 12, 1'b0);
    run_job(3, 0, 7, 1'b0);
    clear_ops();
    add_pair(2, 3, 0);
    add_pair(4, 5, 0);
    run_job(2, 1, 0, 1'b1);

    // Reset asserted during FEED aborts the job
    clear_mon();
    @(negedge clk);
    len       = LEN_W'(2);
    num_res   = (ADDR_W+1)'(1);
    base_addr = '0;
    start     = 1'b1;
    rec       = 1'b1;
    @(posedge clk);
    #1 s0 = cyc;
    @(negedge clk);
    start    = 1'b0;
    op_valid = 1'b1;
    op_north = DATA_W'(2);
    op_west  = DATA_W'(3);
    for (int i = 0; i < 10 && !op_ready; i++) @(negedge clk);
    check("feed_reached", op_ready, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_op_ready", op_ready, 0);
    check("abort_pe_clr", pe_clr, 0);
    check("abort_pe_north", pe_north, 0);
    check("abort_pe_west", pe_west, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_res_idx", res_idx, 0);
    repeat (4) @(negedge clk);
    op_valid = 1'b0;
    check("abort_no_write", wrs.size(), 0);
    rst = 1'b1;
    rec = 1'b0;
    @(negedge clk);
    clear_ops();
    add_pair(2, 3, 0);
    add_pair(4, 5, 0);
    run_job(2, 1, 0, 1'b0);

    // Random jobs
    for (int t = 0; t < 12; t++) begin
      k = int'($urandom_range(0, 5));
      n = int'($urandom_range(0, 4));
      b = int'($urandom_range(0, 63));
      clear_ops();
      for (int i = 0; i < k * n; i++) begin
        add_pair($urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      end
      run_job(k, n, b, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
